// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;

    localparam int SA_DEF_WIDTH = 4;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// SERIAL_ADD_SUB_EN adds the `sub` operand-mode bit.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             cout;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif

    modport master (
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output in_valid, data_a, data_b, out_ready,
        input  in_ready, out_valid, out, cout
    );

    modport slave (
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  in_valid, data_a, data_b, out_ready,
        output in_ready, out_valid, out, cout
    );

endinterface

// File: rtl/serial_fa_cell.sv
// One-bit full adder with a registered carry; init preloads the carry
// before a new serial operation, en advances it by one bit.
module serial_fa_cell (
    input  logic clk,
    input  logic reset,
    input  logic init,
    input  logic cin_init,
    input  logic a,
    input  logic b,
    input  logic en,
    output logic s,
    output logic carry
);

    assign s = a ^ b ^ carry;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            carry <= 1'b0;
        end else if (init) begin
            carry <= cin_init;
        end else if (en) begin
            carry <= (a & b) | (a & carry) | (b & carry);
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: loads an operand pair, adds LSB first over
// WIDTH cycles, then holds sum/carry-out until the consumer accepts.
// Optional subtract mode is enabled by the SERIAL_ADD_SUB_EN macro.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_DEF_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    serial_add_ctrl_if.slave    bus,
    output logic                busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        state;
    sa_state_t        state_next;
    logic             load;
    logic             shift_en;
    logic             result_taken;
    logic [WIDTH-1:0] sr_a;
    logic [WIDTH-1:0] sr_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] out_q;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             carry;
    logic             cin_init;
    logic [WIDTH-1:0] b_load;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1: invert B on load and preset the carry.
    assign cin_init = bus.sub;
    assign b_load   = bus.sub ? ~bus.data_b : bus.data_b;
`else
    assign cin_init = 1'b0;
    assign b_load   = bus.data_b;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        load          = 1'b0;
        shift_en      = 1'b0;
        result_taken  = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    result_taken = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, because out/cout must read 0 right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_a   <= '0;
            sr_b   <= '0;
            res    <= '0;
            cnt    <= '0;
            out_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            if (load) begin
                sr_a <= bus.data_a;
                sr_b <= b_load;
                res  <= '0;
                cnt  <= '0;
            end else if (shift_en) begin
                sr_a <= sr_a >> 1;
                sr_b <= sr_b >> 1;
                res  <= {s, res[WIDTH-1:1]};
                cnt  <= cnt + CW'(1);
            end
            // Snapshot so the result survives the next load clearing res/carry.
            if (result_taken) begin
                out_q  <= res;
                cout_q <= carry;
            end
        end
    end

    serial_fa_cell u_fa (
        .clk      (clk),
        .reset    (reset),
        .init     (load),
        .cin_init (cin_init),
        .a        (sr_a[0]),
        .b        (sr_b[0]),
        .en       (shift_en),
        .s        (s),
        .carry    (carry)
    );

    assign bus.out  = (state == DONE) ? res   : out_q;
    assign bus.cout = (state == DONE) ? carry : cout_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised and directed bench for serial_add_ctrl against an arithmetic model.
// Covers subtract mode when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int WIDTH = SA_DEF_WIDTH;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic busy;
    bit   sub_sel = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {cout, sum}: plain a+b, or a-b with cout meaning "no borrow".
    function automatic logic [WIDTH:0] model(input int a, input int b, input bit s);
        int lim;
        lim = 1 << WIDTH;
        if (s) return {(a >= b) ? 1'b1 : 1'b0, WIDTH'((a - b + lim) % lim)};
        return (WIDTH + 1)'(a + b);
    endfunction

    task automatic send(input int a, input int b, input bit keep);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_accept", bus.in_ready, 1);
        bus.data_a   = a[WIDTH-1:0];
        bus.data_b   = b[WIDTH-1:0];
`ifdef SERIAL_ADD_SUB_EN
        bus.sub      = sub_sel;
`endif
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        if (!keep) bus.in_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        check("in_ready_while_busy", bus.in_ready, 0);
    endtask

    task automatic collect(input int a, input int b, input int bp);
        logic [WIDTH:0] exp;
        int n;
        exp = model(a, b, sub_sel);
        n = 0;
        while (!bus.out_valid && n < 4 * WIDTH) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, WIDTH);
        check("sum", bus.out, exp[WIDTH-1:0]);
        check("cout", bus.cout, exp[WIDTH]);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_sum", bus.out, exp[WIDTH-1:0]);
            check("bp_cout", bus.cout, exp[WIDTH]);
            check("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("out_valid_dropped", bus.out_valid, 0);
        check("in_ready_after_hs", bus.in_ready, 1);
        check("busy_after_hs", busy, 0);
        check("sum_held_idle", bus.out, exp[WIDTH-1:0]);
        check("cout_held_idle", bus.cout, exp[WIDTH]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        bus.in_valid  = 1'b0;
        bus.data_a    = '0;
        bus.data_b    = '0;
        bus.out_ready = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out", bus.out, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed additions.
        send(4'b1000, 4'b0010, 1'b0); collect(4'b1000, 4'b0010, 0);
        send(4'b1111, 4'b0001, 1'b0); collect(4'b1111, 4'b0001, 0);
        send(4'b1111, 4'b1111, 1'b0); collect(4'b1111, 4'b1111, 0);

        // Backpressure for five cycles.
        send(4'b0110, 4'b0111, 1'b0); collect(4'b0110, 4'b0111, 5);

        // Operands held valid while busy: the first result is unaffected,
        // the held pair is accepted only once in_ready returns.
        send(4'b0101, 4'b0101, 1'b1);
        bus.data_a = 4'b0011;
        bus.data_b = 4'b0100;
        collect(4'b0101, 4'b0101, 2);
        send(4'b0011, 4'b0100, 1'b0); collect(4'b0011, 4'b0100, 0);

        // Reset in the second SHIFT cycle aborts the operation.
        send(4'b0101, 4'b0110, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_out", bus.out, 0);
        check("abort_cout", bus.cout, 0);
        check("abort_busy", busy, 0);
        send(4'b1001, 4'b0011, 1'b0); collect(4'b1001, 4'b0011, 0);

`ifdef SERIAL_ADD_SUB_EN
        sub_sel = 1'b1;
        send(4'b0010, 4'b1000, 1'b0); collect(4'b0010, 4'b1000, 0);
        send(4'b1000, 4'b0010, 1'b0); collect(4'b1000, 4'b0010, 0);
        sub_sel = 1'b0;
`endif

        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, (1 << WIDTH) - 1));
            b = int'($urandom_range(0, (1 << WIDTH) - 1));
`ifdef SERIAL_ADD_SUB_EN
            sub_sel = bit'($urandom_range(0, 1));
`endif
            send(a, b, 1'b0);
            collect(a, b, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
